// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised sources with edge/level detect, masking and fixed priority,
// configured and acknowledged over the execute stage's special-register bus.
module irq_ctrl #(
    parameter int unsigned     N_SRC     = 8,
    parameter int unsigned     RW        = 16,
    parameter logic [RW-1:0]   BASE_ADDR = 16'h0200
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_src,
    input  logic [RW-1:0]    sr_bus_addr,
    input  logic [RW-1:0]    sr_bus_data_i,
    input  logic             sr_bus_we,
    output logic [RW-1:0]    sr_bus_data_o,
    output logic             o_irq,
    input  logic             i_irq_taken,
    output logic [3:0]       o_active_id
);

    localparam logic [RW-1:0] ADDR_PEND = BASE_ADDR;
    localparam logic [RW-1:0] ADDR_MASK = BASE_ADDR + RW'(1);
    localparam logic [RW-1:0] ADDR_EDGE = BASE_ADDR + RW'(2);
    localparam logic [RW-1:0] ADDR_VEC  = BASE_ADDR + RW'(3);
    localparam logic [RW-1:0] ADDR_RAW  = BASE_ADDR + RW'(4);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e             state_q, state_d;
    logic [N_SRC-1:0]   s1_q, s2_q, s3_q;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [N_SRC-1:0]   edge_q, edge_d;
    logic [3:0]         active_id_q, active_id_d;
    logic               isv_q, isv_d;

    logic [N_SRC-1:0]   req, edge_set, w1c, take_clr, wdata;
    logic [3:0]         winner;
    logic               take;
    logic               we_pend, we_mask, we_edge, we_vec;
    logic               unused_wdata;

    assign wdata        = sr_bus_data_i[N_SRC-1:0];
    assign unused_wdata = ^sr_bus_data_i[RW-1:N_SRC];

    assign we_pend = sr_bus_we && (sr_bus_addr == ADDR_PEND);
    assign we_mask = sr_bus_we && (sr_bus_addr == ADDR_MASK);
    assign we_edge = sr_bus_we && (sr_bus_addr == ADDR_EDGE);
    assign we_vec  = sr_bus_we && (sr_bus_addr == ADDR_VEC);

    assign req = pending_q & mask_q;

    // Lowest index wins.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) winner = 4'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        isv_d       = isv_q;
        take        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) state_d = StReq;
            end
            StReq: begin
                if (~|req) begin
                    state_d = StIdle;
                end else if (i_irq_taken) begin
                    take        = 1'b1;
                    active_id_d = winner;
                    isv_d       = 1'b1;
                    state_d     = StService;
                end
            end
            StService: begin
                if (we_vec) begin
                    state_d     = StIdle;
                    isv_d       = 1'b0;
                    active_id_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A fresh edge beats both the W1C and the acknowledge clear in the same cycle.
    always_comb begin
        edge_set = edge_q & s2_q & ~s3_q;
        w1c      = we_pend ? wdata : '0;
        for (int i = 0; i < N_SRC; i++) begin
            take_clr[i] = take && (winner == 4'(i));
        end
        pending_d = (edge_q & (edge_set | (pending_q & ~w1c & ~take_clr))) | (~edge_q & s2_q);
        mask_d    = we_mask ? wdata : mask_q;
        edge_d    = we_edge ? wdata : edge_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            edge_q      <= '0;
            active_id_q <= '0;
            isv_q       <= 1'b0;
            state_q     <= StIdle;
        end else begin
            s1_q        <= i_src;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            edge_q      <= edge_d;
            active_id_q <= active_id_d;
            isv_q       <= isv_d;
            state_q     <= state_d;
        end
    end

    always_comb begin
        sr_bus_data_o = '0;
        case (sr_bus_addr)
            ADDR_PEND: sr_bus_data_o[N_SRC-1:0] = pending_q;
            ADDR_MASK: sr_bus_data_o[N_SRC-1:0] = mask_q;
            ADDR_EDGE: sr_bus_data_o[N_SRC-1:0] = edge_q;
            ADDR_VEC: begin
                sr_bus_data_o[15]  = isv_q;
                sr_bus_data_o[3:0] = active_id_q;
            end
            ADDR_RAW:  sr_bus_data_o[N_SRC-1:0] = s2_q;
            default:   sr_bus_data_o = '0;
        endcase
    end

    assign o_irq       = (state_q == StReq);
    assign o_active_id = active_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register table, directed corner sequences and a randomized
// run against a spec-level reference model.
module tb_irq_ctrl;

    localparam logic [15:0] BASE   = 16'h0200;
    localparam logic [15:0] A_PEND = BASE;
    localparam logic [15:0] A_MASK = BASE + 16'd1;
    localparam logic [15:0] A_EDGE = BASE + 16'd2;
    localparam logic [15:0] A_VEC  = BASE + 16'd3;
    localparam logic [15:0] A_RAW  = BASE + 16'd4;

    logic        clk, rst, we, taken, irq;
    logic [7:0]  src;
    logic [15:0] addr, wdata, rdata;
    logic [3:0]  active_id;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(.N_SRC(8), .RW(16), .BASE_ADDR(16'h0200)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_src         (src),
        .sr_bus_addr   (addr),
        .sr_bus_data_i (wdata),
        .sr_bus_we     (we),
        .sr_bus_data_o (rdata),
        .o_irq         (irq),
        .i_irq_taken   (taken),
        .o_active_id   (active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [15:0] a, input logic [15:0] exp);
        addr = a;
        we   = 1'b0;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic take_irq();
        taken = 1'b1;
        tick();
        taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int budget);
        int n = 0;
        while (!irq && n < budget) begin
            tick();
            n++;
        end
        check(name, {15'b0, irq}, 16'h0001);
    endtask

    // Reference model: sync pipeline as a queue (entry 0 = newest), registers as plain vectors.
    bit [7:0] m_sync[$];
    bit [7:0] m_pend, m_mask, m_edge;
    int       m_phase;   // 0 idle, 1 requesting, 2 in service
    bit [3:0] m_id;
    bit       m_v;

    task automatic model_reset();
        m_sync  = {8'h00, 8'h00, 8'h00};
        m_pend  = 0;
        m_mask  = 0;
        m_edge  = 0;
        m_phase = 0;
        m_id    = 0;
        m_v     = 0;
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        case (a)
            A_PEND:  return {8'h00, m_pend};
            A_MASK:  return {8'h00, m_mask};
            A_EDGE:  return {8'h00, m_edge};
            A_VEC:   return {m_v, 11'b0, m_id};
            A_RAW:   return {8'h00, m_sync[1]};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_step(input bit [7:0] s, input logic [15:0] a, input bit w,
                              input logic [15:0] d, input bit tk);
        bit [7:0] req = m_pend & m_mask;
        bit [7:0] np;
        int       win = -1;
        bit       ack;
        for (int i = 0; i < 8; i++) if (req[i] && win < 0) win = i;
        ack = (m_phase == 1) && (req != 0) && tk;
        for (int i = 0; i < 8; i++) begin
            if (m_edge[i]) begin
                bit rise = m_sync[1][i] && !m_sync[2][i];
                bit clr  = (w && a == A_PEND && d[i]) || (ack && i == win);
                np[i] = rise || (m_pend[i] && !clr);
            end else begin
                np[i] = m_sync[1][i];
            end
        end
        case (m_phase)
            0: if (req != 0) m_phase = 1;
            1: begin
                if (req == 0) m_phase = 0;
                else if (tk) begin
                    m_phase = 2;
                    m_id    = 4'(win);
                    m_v     = 1;
                end
            end
            default: if (w && a == A_VEC) begin
                m_phase = 0;
                m_v     = 0;
                m_id    = 0;
            end
        endcase
        m_pend = np;
        if (w && a == A_MASK) m_mask = d[7:0];
        if (w && a == A_EDGE) m_edge = d[7:0];
        m_sync.push_front(s);
        void'(m_sync.pop_back());
    endtask

    typedef struct {
        string       name;
        logic        do_wr;
        logic [15:0] wr_addr;
        logic [15:0] wr_data;
        logic [15:0] rd_addr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        rst = 1'b1; we = 1'b0; taken = 1'b0; src = '0; addr = '0; wdata = '0;

        vecs[0]  = '{"mask_hi_drop",  1'b1, A_MASK,       16'hFFFF, A_MASK,       16'h00FF};
        vecs[1]  = '{"edge_write",    1'b1, A_EDGE,       16'h1234, A_EDGE,       16'h0034};
        vecs[2]  = '{"win_plus7",     1'b1, BASE + 16'd7, 16'hFFFF, BASE + 16'd7, 16'h0000};
        vecs[3]  = '{"outside_win",   1'b1, 16'h0100,     16'hFFFF, 16'h0100,     16'h0000};
        vecs[4]  = '{"mask_kept",     1'b0, A_MASK,       16'h0000, A_MASK,       16'h00FF};
        vecs[5]  = '{"edge_kept",     1'b0, A_EDGE,       16'h0000, A_EDGE,       16'h0034};
        vecs[6]  = '{"vec_idle",      1'b0, A_VEC,        16'h0000, A_VEC,        16'h0000};
        vecs[7]  = '{"raw_idle",      1'b0, A_RAW,        16'h0000, A_RAW,        16'h0000};
        vecs[8]  = '{"pend_idle",     1'b0, A_PEND,       16'h0000, A_PEND,       16'h0000};
        vecs[9]  = '{"win_plus5",     1'b1, BASE + 16'd5, 16'hAAAA, BASE + 16'd5, 16'h0000};
        vecs[10] = '{"mask_clear",    1'b1, A_MASK,       16'h0000, A_MASK,       16'h0000};
        vecs[11] = '{"edge_clear",    1'b1, A_EDGE,       16'h0000, A_EDGE,       16'h0000};

        do_reset();
        check("rst_irq", {15'b0, irq}, 16'h0000);
        check("rst_id", {12'b0, active_id}, 16'h0000);
        chk_rd("rst_mask", A_MASK, 16'h0000);

        foreach (vecs[i]) begin
            if (vecs[i].do_wr) wr(vecs[i].wr_addr, vecs[i].wr_data);
            chk_rd(vecs[i].name, vecs[i].rd_addr, vecs[i].exp);
        end

        // Single edge source, latency and acknowledge.
        do_reset();
        wr(A_MASK, 16'h0001);
        wr(A_EDGE, 16'h0001);
        src = 8'h01;
        tick(); tick(); tick();
        chk_rd("a_pend_e2", A_PEND, 16'h0001);
        check("a_irq_e2", {15'b0, irq}, 16'h0000);
        src = 8'h00;
        tick();
        check("a_irq_e3", {15'b0, irq}, 16'h0001);
        take_irq();
        check("a_id", {12'b0, active_id}, 16'h0000);
        chk_rd("a_vec", A_VEC, 16'h8000);
        chk_rd("a_pend_clr", A_PEND, 16'h0000);
        check("a_irq_off", {15'b0, irq}, 16'h0000);
        wr(A_VEC, 16'h0000);
        chk_rd("a_vec_eoi", A_VEC, 16'h0000);
        tick();
        check("a_idle", {15'b0, irq}, 16'h0000);

        // Priority between two simultaneous edge sources.
        do_reset();
        wr(A_MASK, 16'h00FF);
        wr(A_EDGE, 16'h00FF);
        src = 8'h24;
        wait_irq("b_irq1", 10);
        take_irq();
        check("b_id2", {12'b0, active_id}, 16'h0002);
        wr(A_VEC, 16'h0000);
        check("b_irq_gap", {15'b0, irq}, 16'h0000);
        tick();
        check("b_irq_re", {15'b0, irq}, 16'h0001);
        take_irq();
        check("b_id5", {12'b0, active_id}, 16'h0005);
        chk_rd("b_pend0", A_PEND, 16'h0000);
        src = 8'h00;
        wr(A_VEC, 16'h0000);

        // Level source re-requests after EOI, then falls away when released.
        do_reset();
        wr(A_MASK, 16'h0008);
        src = 8'h08;
        wait_irq("c_irq1", 10);
        take_irq();
        check("c_id3", {12'b0, active_id}, 16'h0003);
        wr(A_VEC, 16'h0000);
        tick();
        check("c_irq_re", {15'b0, irq}, 16'h0001);
        src = 8'h00;
        tick(); tick(); tick();
        chk_rd("c_pend_drop", A_PEND, 16'h0000);
        tick();
        check("c_irq_drop", {15'b0, irq}, 16'h0000);

        // Masking while requesting.
        do_reset();
        wr(A_MASK, 16'h0002);
        wr(A_EDGE, 16'h0002);
        src = 8'h02;
        tick(); tick();
        src = 8'h00;
        wait_irq("d_irq1", 10);
        wr(A_MASK, 16'h0000);
        tick();
        check("d_irq_masked", {15'b0, irq}, 16'h0000);
        chk_rd("d_pend_kept", A_PEND, 16'h0002);
        wr(A_MASK, 16'h0002);
        tick();
        check("d_irq_back", {15'b0, irq}, 16'h0001);

        // W1C colliding with a new edge, plus ignored writes.
        do_reset();
        wr(A_EDGE, 16'h0001);
        src = 8'h01;
        tick(); tick(); tick();
        src = 8'h00;
        chk_rd("e_pend_set", A_PEND, 16'h0001);
        wr(A_PEND, 16'h0001);
        chk_rd("e_w1c", A_PEND, 16'h0000);
        tick(); tick(); tick();
        src = 8'h01;
        tick(); tick();
        wr(A_PEND, 16'h0001);
        chk_rd("e_set_wins", A_PEND, 16'h0001);
        src = 8'h00;
        wr(BASE + 16'd7, 16'h00FF);
        wr(16'h0100, 16'h00FF);
        chk_rd("e_mask_untouched", A_MASK, 16'h0000);
        chk_rd("e_pend_untouched", A_PEND, 16'h0001);
        chk_rd("e_rd7", BASE + 16'd7, 16'h0000);

        // Reset while in service.
        do_reset();
        wr(A_MASK, 16'h00FF);
        wr(A_EDGE, 16'h00FF);
        src = 8'h10;
        wait_irq("f_irq1", 10);
        take_irq();
        src = 8'h00;
        chk_rd("f_vec_svc", A_VEC, 16'h8004);
        rst = 1'b1;
        tick();
        check("f_irq", {15'b0, irq}, 16'h0000);
        check("f_id", {12'b0, active_id}, 16'h0000);
        chk_rd("f_mask", A_MASK, 16'h0000);
        chk_rd("f_pend", A_PEND, 16'h0000);
        chk_rd("f_vec", A_VEC, 16'h0000);
        rst = 1'b0;

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [15:0] a;
            bit          w, tk;
            logic [15:0] d;
            bit [7:0]    s;
            s = src;
            for (int b = 0; b < 8; b++) if ($urandom_range(7) == 0) s[b] = ~s[b];
            case ($urandom_range(6))
                0: a = A_PEND;
                1: a = A_MASK;
                2: a = A_EDGE;
                3: a = A_VEC;
                4: a = A_RAW;
                5: a = BASE + 16'd5;
                default: a = 16'h0100;
            endcase
            w  = ($urandom_range(5) == 0);
            d  = 16'($urandom);
            tk = ($urandom_range(3) == 0);
            src = s; addr = a; wdata = d; we = w; taken = tk;
            #1;
            check("rnd_irq", {15'b0, irq}, {15'b0, m_phase == 1});
            check("rnd_id", {12'b0, active_id}, {12'b0, m_id});
            check("rnd_rd", rdata, model_read(a));
            tick();
            model_step(s, a, w, d, tk);
        end
        we = 1'b0;
        taken = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller feeding the single `i_irq` input of the execute stage.
- Collects N_SRC external interrupt sources through 2-FF synchronisers. Supports per-source edge/level mode, masking, pending and in-service tracking.
- Fixed-priority arbitration between sources.
- Software configures and acknowledges it through the special-register bus (sr_bus_addr / sr_bus_data / sr_bus_we) driven by the execute stage, in a window starting at BASE_ADDR.

Parameters:
N_SRC, 8, number of interrupt sources (1..15)
BASE_ADDR, 16'h0200, first special-register address of the controller window
RW, 16, register/bus width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_src  in  N_SRC  raw asynchronous interrupt lines, active-high
sr_bus_addr  in  RW  special-register address from execute
sr_bus_data_i  in  RW  write data from execute
sr_bus_we  in  1  write strobe, one cycle per executed store
sr_bus_data_o  out  RW  combinational read data for sr_bus_addr
o_irq  out  1  registered interrupt request to execute (`i_irq`)
i_irq_taken  in  1  one-cycle pulse when the CPU enters the interrupt handler
o_active_id  out  4  id of the in-service source, 0 when none

Behaviour:
- Reset: all sync flops, PENDING, MASK, EDGE_MODE = 0; state IDLE; o_irq = 0; o_active_id = 0; in-service valid = 0.
- Sync and detect: s1 <= i_src, s2 <= s1, s3 <= s2.
  - Edge source (EDGE_MODE[i]=1): set PENDING[i] when s2 & ~s3.
  - Level source: PENDING[i] <= s2 every cycle; W1C on level sources is ignored.
- Register map, offset from BASE_ADDR:
  - +0 PENDING: read; write-1-to-clear for edge sources.
  - +1 MASK: rw; 1 = enabled.
  - +2 EDGE_MODE: rw.
  - +3 VECTOR: read {in_service_valid at bit15, 11'b0, active id[3:0]}; any write = EOI.
  - +4 RAW: read s2.
  - Other addresses read 0. Writes outside the window are ignored.
  - Bits at N_SRC and above read 0; writes to them are dropped.
- Arbitration: req = PENDING & MASK; winner = lowest set index (index 0 has highest priority).
- FSM (o_irq = 1 only in REQ):
  - IDLE: go to REQ when req != 0.
  - REQ, i_irq_taken = 1: latch winner into o_active_id and set in-service valid; clear PENDING[winner] if it is an edge source; go to SERVICE.
  - REQ, req == 0 (masked or cleared before taken): return to IDLE, o_irq drops next cycle.
  - SERVICE: no nesting, o_irq = 0. On an EOI write go to IDLE, clear in-service valid, set o_active_id to 0.
- Latency: a source sampled high at edge E0 sets PENDING at E2 and o_irq = 1 after E3. After EOI with req still nonzero, o_irq reasserts after the 2nd following edge (via IDLE).
- Simultaneous events:
  - An edge detect and a W1C on the same bit in the same cycle: set wins.
  - An edge detect and the i_irq_taken clear on the same bit: set wins, so the source stays pending for the next round.
  - i_irq_taken while IDLE or SERVICE is ignored.
  - EOI while IDLE or REQ is ignored.
  - A MASK write in the same cycle as i_irq_taken: arbitration uses the old MASK.
- Level source remaining high after EOI re-requests, which is the intended behaviour.
- Reset mid-operation, in any state: returns to IDLE and clears all state on the next edge. o_irq is low in the cycle after reset is sampled.

Test Plan:
- Reset, MASK=0x01, EDGE_MODE=0x01, pulse i_src[0] for 1 cycle longer than 2 clocks -> PENDING=0x01, o_irq=1 three edges after sampling. Then pulse i_irq_taken -> o_active_id=0, VECTOR=0x8000, PENDING=0x00, o_irq=0. Write VECTOR -> VECTOR=0x0000, state IDLE.
- MASK=0xFF, all edge sources, raise i_src[5] and i_src[2] together -> i_irq_taken gives id 2. EOI -> o_irq reasserts, next taken gives id 5.
- Level source 3 held high, MASK=0x08 -> taken and EOI -> o_irq reasserts. Drop i_src[3] -> PENDING[3]=0 three edges later, o_irq=0.
- o_irq=1 for edge source 1, then write MASK=0 -> o_irq=0 next cycle, PENDING still 0x02. Restore MASK=0x02 -> o_irq=1 again.
- W1C PENDING=0x01 in the same cycle as a new edge on source 0 -> PENDING[0] stays 1. Write to BASE_ADDR+7 and to 0x0100 -> no register changes, reads return 0.
- Assert i_rst while in SERVICE with MASK=0xFF -> o_irq=0, o_active_id=0, MASK=0, PENDING=0 on the following cycle.
